bpsk_bit_source: RTL and testbench

Generates the `modulator` data bit consumed by the BPSK modulator stage directly downstream. Each output bit is either a 5-bit LFSR pseudo-random sequence or a programmable 16-bit pattern. Bit changes happen only on carrier phase-wrap boundaries, so the phase flip in the modulated sin/cos/square/saw outputs occurs at a carrier cycle edge. Each symbol lasts a programmable number of carrier cycles.

---
 rtl/bpsk_bit_source.sv | 141 ++++++++++++++
 tb/tb_bpsk_bit_source.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/bpsk_bit_source.sv
// Data-bit source for the BPSK modulator: LFSR or fixed pattern, one symbol per
// programmable number of carrier cycles, with bit changes aligned to phase wraps.
module bpsk_bit_source #(
  parameter int PAT_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] cycles_per_symbol,
  input  logic [PAT_W-1:0] pattern,
  input  logic             phase_wrap,
  output logic             modulator,
  output logic             symbol_strobe,
  output logic             aligned,
  output logic [15:0]      symbol_count
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_ALIGN = 2'd1,
    ST_RUN        = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [4:0]       lfsr_q, lfsr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [CNT_W-1:0] cps_sh_q, cps_sh_d;
  logic             modulator_q, modulator_d;
  logic             strobe_q, strobe_d;
  logic             aligned_q, aligned_d;
  logic [15:0]      count_q, count_d;

  logic [4:0]       lfsr_cur;
  logic [CNT_W-1:0] eff_cps;
  logic [IDX_W-1:0] pat_sel;
  logic             emit;

  // The output bit is resolved from mode/pattern at the emission instant, so
  // only the symbol length needs a shadow copy to survive until the boundary.
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    idx_d       = idx_q;
    cyc_cnt_d   = cyc_cnt_q;
    cps_sh_d    = cps_sh_q;
    modulator_d = modulator_q;
    strobe_d    = 1'b0;
    count_d     = count_q;
    emit        = 1'b0;

    lfsr_cur = (lfsr_q == 5'd0) ? 5'b00001 : lfsr_q;
    eff_cps  = (cps_sh_q == '0) ? CNT_W'(1) : cps_sh_q;
    pat_sel  = IDX_W'(PAT_W - 1) - idx_q;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_WAIT_ALIGN;
      end
      ST_WAIT_ALIGN: begin
        if (phase_wrap) begin
          emit    = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (phase_wrap) begin
          if (cyc_cnt_q == eff_cps - CNT_W'(1)) emit = 1'b1;
          else cyc_cnt_d = cyc_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (emit) begin
      cyc_cnt_d = '0;
      cps_sh_d  = cycles_per_symbol;
      strobe_d  = 1'b1;
      count_d   = count_q + 16'd1;
      case (mode)
        2'b00: begin
          modulator_d = lfsr_cur[4];
          lfsr_d      = {lfsr_cur[3:0], lfsr_cur[4] ^ lfsr_cur[2]};
        end
        2'b01: begin
          modulator_d = pattern[pat_sel];
          idx_d       = (idx_q == IDX_W'(PAT_W - 1)) ? '0 : idx_q + IDX_W'(1);
        end
        2'b10:   modulator_d = 1'b0;
        default: modulator_d = 1'b1;
      endcase
    end

    // Disable wins over any wrap in the same cycle; symbol_count is since-reset.
    if (!enable) begin
      state_d     = ST_IDLE;
      lfsr_d      = 5'b00001;
      idx_d       = '0;
      cyc_cnt_d   = '0;
      modulator_d = 1'b1;
      strobe_d    = 1'b0;
      count_d     = count_q;
    end

    aligned_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      lfsr_q      <= 5'b00001;
      idx_q       <= '0;
      cyc_cnt_q   <= '0;
      cps_sh_q    <= '0;
      modulator_q <= 1'b1;
      strobe_q    <= 1'b0;
      aligned_q   <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      idx_q       <= idx_d;
      cyc_cnt_q   <= cyc_cnt_d;
      cps_sh_q    <= cps_sh_d;
      modulator_q <= modulator_d;
      strobe_q    <= strobe_d;
      aligned_q   <= aligned_d;
      count_q     <= count_d;
    end
  end

  assign modulator     = modulator_q;
  assign symbol_strobe = strobe_q;
  assign aligned       = aligned_q;
  assign symbol_count  = count_q;

endmodule

// File: tb/tb_bpsk_bit_source.sv
// Directed bench for bpsk_bit_source: table of per-symbol vectors plus
// hand-written sequences for alignment, enable and reset corner cases.
module tb_bpsk_bit_source;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [1:0]  mode;
  logic [7:0]  cps;
  logic [15:0] pattern;
  logic        phase_wrap;
  logic        modulator;
  logic        symbol_strobe;
  logic        aligned;
  logic [15:0] symbol_count;

  bpsk_bit_source #(.PAT_W(16), .CNT_W(8)) dut (
    .clk               (clk),
    .reset             (reset),
    .enable            (enable),
    .mode              (mode),
    .cycles_per_symbol (cps),
    .pattern           (pattern),
    .phase_wrap        (phase_wrap),
    .modulator         (modulator),
    .symbol_strobe     (symbol_strobe),
    .aligned           (aligned),
    .symbol_count      (symbol_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic [7:0]  cps;
    logic [15:0] pat;
    logic        bit_exp;
    int          len;
  } vec_t;

  vec_t        tbl[23];
  int          n_pass  = 0;
  int          n_total = 0;
  logic [15:0] exp_count;
  logic [4:0]  m_lfsr;
  logic [30:0] seq;
  logic        b;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the sampling posedge.
  task automatic do_wrap();
    phase_wrap = 1'b1;
    @(negedge clk);
    phase_wrap = 1'b0;
  endtask

  function automatic logic model_bit();
    logic o;
    o      = m_lfsr[4];
    m_lfsr = {m_lfsr[3:0], m_lfsr[4] ^ m_lfsr[2]};
    return o;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] p;
    p = 16'hA5F0;
    for (int i = 0; i < 16; i++) tbl[i] = '{2'b01, 8'd3, p, p[15-i], 3};
    tbl[16] = '{2'b01, 8'd0, 16'hA5F0, 1'b1, 1};
    tbl[17] = '{2'b01, 8'd0, 16'hA5F0, 1'b0, 1};
    tbl[18] = '{2'b10, 8'd2, 16'hA5F0, 1'b0, 2};
    tbl[19] = '{2'b11, 8'd1, 16'hA5F0, 1'b1, 1};
    tbl[20] = '{2'b01, 8'd4, 16'h2000, 1'b1, 4};
    tbl[21] = '{2'b00, 8'd1, 16'h0000, 1'b0, 1};
    tbl[22] = '{2'b00, 8'd1, 16'h0000, 1'b0, 1};

    reset = 1'b1; enable = 1'b0; mode = 2'b00; cps = 8'd1;
    pattern = 16'h0000; phase_wrap = 1'b0;
    #12;
    chk("reset_modulator", modulator, 1);
    chk("reset_strobe", symbol_strobe, 0);
    chk("reset_aligned", aligned, 0);
    chk("reset_count", symbol_count, 0);

    // LFSR, cps=1, one wrap every 10 cycles
    @(negedge clk);
    reset = 1'b0; enable = 1'b1;
    idle_cycles(2);
    chk("wait_aligned", aligned, 0);
    chk("wait_modulator", modulator, 1);
    m_lfsr = 5'b00001; exp_count = 0;
    for (int i = 0; i < 31; i++) begin
      do_wrap();
      b = model_bit(); exp_count++;
      seq[i] = modulator;
      chk("lfsr_bit", modulator, b);
      chk("lfsr_strobe", symbol_strobe, 1);
      idle_cycles(1);
      chk("lfsr_strobe_low", symbol_strobe, 0);
      idle_cycles(8);
    end
    chk("lfsr_first5", {seq[4], seq[3], seq[2], seq[1], seq[0]}, 5'b10000);
    chk("lfsr_count31", symbol_count, 31);
    chk("lfsr_aligned", aligned, 1);
    do_wrap(); b = model_bit(); exp_count++;
    chk("lfsr_period", modulator, seq[0]);
    chk("lfsr_period_model", modulator, b);

    // Table: disable/re-enable for a fresh index and seed, then back-to-back wraps
    enable = 1'b0;
    idle_cycles(1);
    chk("dis_modulator", modulator, 1);
    chk("dis_aligned", aligned, 0);
    enable = 1'b1;
    idle_cycles(2);
    for (int r = 0; r < 23; r++) begin
      mode = tbl[r].mode; cps = tbl[r].cps; pattern = tbl[r].pat;
      do_wrap(); exp_count++;
      chk($sformatf("tbl%0d_bit", r), modulator, tbl[r].bit_exp);
      chk($sformatf("tbl%0d_strobe", r), symbol_strobe, 1);
      chk($sformatf("tbl%0d_count", r), symbol_count, exp_count);
      for (int k = 1; k < tbl[r].len; k++) begin
        do_wrap();
        chk($sformatf("tbl%0d_hold_strobe", r), symbol_strobe, 0);
        chk($sformatf("tbl%0d_hold_bit", r), modulator, tbl[r].bit_exp);
      end
    end

    // cps 2 -> 5 mid-symbol: current symbol still 2 wraps, next lasts 5
    mode = 2'b11; cps = 8'd2;
    do_wrap(); exp_count++;
    chk("cps_chg_start", symbol_strobe, 1);
    cps = 8'd5;
    do_wrap();
    chk("cps_chg_mid", symbol_strobe, 0);
    do_wrap(); exp_count++;
    chk("cps_chg_end2", symbol_strobe, 1);
    for (int k = 0; k < 4; k++) begin
      do_wrap();
      chk("cps5_hold", symbol_strobe, 0);
    end
    do_wrap(); exp_count++;
    chk("cps5_end", symbol_strobe, 1);
    chk("cps5_count", symbol_count, exp_count);

    // enable low on a boundary wrap
    for (int k = 0; k < 4; k++) do_wrap();
    enable = 1'b0; phase_wrap = 1'b1;
    @(negedge clk);
    phase_wrap = 1'b0;
    chk("dis_bnd_strobe", symbol_strobe, 0);
    chk("dis_bnd_modulator", modulator, 1);
    chk("dis_bnd_count", symbol_count, exp_count);
    chk("dis_bnd_aligned", aligned, 0);
    enable = 1'b1; phase_wrap = 1'b1;
    @(negedge clk);
    phase_wrap = 1'b0;
    chk("en_rise_wrap_ignored", symbol_strobe, 0);
    mode = 2'b00; cps = 8'd1;
    idle_cycles(1);
    chk("en_rise_modulator", modulator, 1);
    m_lfsr = 5'b00001;
    for (int i = 0; i < 6; i++) begin
      do_wrap(); b = model_bit(); exp_count++;
      chk("reseed_bit", modulator, b);
      chk("reseed_strobe", symbol_strobe, 1);
    end
    chk("reseed_aligned", aligned, 1);
    chk("reseed_count", symbol_count, exp_count);

    // async reset mid-run, between clock edges
    #2 reset = 1'b1;
    #1;
    chk("areset_modulator", modulator, 1);
    chk("areset_strobe", symbol_strobe, 0);
    chk("areset_aligned", aligned, 0);
    chk("areset_count", symbol_count, 0);
    @(negedge clk);
    reset = 1'b0;
    idle_cycles(2);
    chk("post_reset_idle_strobe", symbol_strobe, 0);
    m_lfsr = 5'b00001;
    do_wrap(); b = model_bit();
    chk("post_reset_bit", modulator, b);
    chk("post_reset_strobe", symbol_strobe, 1);
    chk("post_reset_count", symbol_count, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
